// File: rtl/seq_udiv_pkg.sv
// Shared definitions for the sequential unsigned divider: FSM encoding and
// the width helper used to size the step counter.
package seq_udiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest w with 2**w >= value; the counter is sized with clog2(N+1).
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_udiv_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and either commit the difference or keep the shifted value.
module udiv_step #(
    parameter int M = 8
) (
    input  logic [M:0]   i_p,
    input  logic         i_a_msb,
    input  logic [M-1:0] i_b,
    output logic [M:0]   o_p_next,
    output logic         o_qbit
);

    logic [M:0]   w_pn;
    logic [M+1:0] w_sub;
    logic         w_borrow;
    // P is always below B after a step, so its top bit never reaches Pn.
    logic         w_unused_p_msb;

    assign w_unused_p_msb = i_p[M];
    assign w_pn           = {i_p[M-1:0], i_a_msb};

    uSUB_ #(
        .N (M + 1),
        .M (M)
    ) u_sub (
        .A (w_pn),
        .B (i_b),
        .O (w_sub)
    );

    assign w_borrow = w_sub[M+1];
    assign o_p_next = w_borrow ? w_pn : w_sub[M:0];
    assign o_qbit   = ~w_borrow;

endmodule

// File: rtl/uSUB_.sv
// Library unsigned subtractor: O = A - B with the borrow in O[N].
// B is zero-extended to the width of A before subtracting.
module uSUB_ #(
    parameter int N = 8,
    parameter int M = N
) (
    input  logic [N-1:0] A,
    input  logic [M-1:0] B,
    output logic [N:0]   O
);

    assign O = {1'b0, A} - {{(N + 1 - M){1'b0}}, B};

endmodule

// File: rtl/seq_udiv.sv
// Iterative unsigned restoring divider producing one quotient bit per clock.
// Handshake: start is accepted in IDLE or DONE only; done pulses one cycle with Q/R/dbz.
module seq_udiv
    import seq_udiv_pkg::*;
#(
    parameter int N = 8,
    parameter int M = N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [M-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [M-1:0] R,
    output logic         dbz,
    output logic [1:0]   o_dbg_state
);

    localparam int CW = clog2(N + 1);

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_a;
    logic [M-1:0]  r_b;
    logic [M:0]    r_p;
    logic [N-1:0]  r_q;
    logic [M-1:0]  r_r;
    logic          r_dbz;

    logic          w_accept;
    logic          w_last;
    logic [M:0]    w_p_next;
    logic          w_qbit;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_cnt == CW'(N - 1));

    udiv_step #(
        .M (M)
    ) u_step (
        .i_p      (r_p),
        .i_a_msb  (r_a[N-1]),
        .i_b      (r_b),
        .o_p_next (w_p_next),
        .o_qbit   (w_qbit)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)   w_state_next = ST_DONE;
            ST_DONE: w_state_next = w_accept ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_p     <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a   <= A;
                r_b   <= B;
                r_p   <= '0;
                r_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                // Quotient bits fill the dividend register from the bottom.
                r_a   <= {r_a[N-2:0], w_qbit};
                r_p   <= w_p_next;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_q   <= {r_a[N-2:0], w_qbit};
                    r_r   <= w_p_next[M-1:0];
                    r_dbz <= (r_b == '0);
                end
            end
        end
    end

    assign busy        = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign Q           = r_q;
    assign R           = r_r;
    assign dbz         = r_dbz;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_seq_udiv.sv
// Directed bench for seq_udiv: an N=8/M=4 instance for protocol and hold
// behaviour, and an N=M=8 instance for a quotient/remainder sweep.
module tb_seq_udiv;

    logic       clk;
    logic       rst;

    logic       start4;
    logic [7:0] a4;
    logic [3:0] b4;
    logic       busy4, done4, dbz4;
    logic [7:0] q4;
    logic [3:0] r4;
    logic [1:0] st4;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8, done8, dbz8;
    logic [7:0] q8;
    logic [7:0] r8;
    logic [1:0] st8;

    int n_checks;
    int n_errors;

    seq_udiv #(.N(8), .M(4)) dut4 (
        .clk (clk), .rst (rst), .start (start4), .A (a4), .B (b4),
        .busy (busy4), .done (done4), .Q (q4), .R (r4), .dbz (dbz4),
        .o_dbg_state (st4)
    );

    seq_udiv #(.N(8), .M(8)) dut8 (
        .clk (clk), .rst (rst), .start (start8), .A (a8), .B (b8),
        .busy (busy8), .done (done8), .Q (q8), .R (r8), .dbz (dbz8),
        .o_dbg_state (st8)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Start pulse in cycle 0, busy in cycles 1..8, done in cycle 9.
    // Outputs must hold the previous result (hq/hr/hd) until done.
    task automatic run_div4(input string tag, input logic [7:0] a, input logic [3:0] b,
                            input logic [7:0] eq, input logic [3:0] er, input logic ed,
                            input logic [7:0] hq, input logic [3:0] hr, input logic hd,
                            input bit poke);
        a4 = a;
        b4 = b;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            a4 = 8'($urandom_range(0, 255));
            b4 = 4'($urandom_range(0, 15));
            start4 = poke && (c == 3 || c == 5);
            check({tag, " busy/done"}, {busy4, done4}, 2'b10);
            check({tag, " hold"}, {q4, r4, dbz4}, {hq, hr, hd});
            tick();
        end
        start4 = 1'b0;
        check({tag, " done"}, {busy4, done4}, 2'b01);
        check({tag, " Q"}, q4, eq);
        check({tag, " R"}, r4, er);
        check({tag, " dbz"}, dbz4, ed);
        tick();
        check({tag, " idle"}, {busy4, done4, st4}, 4'b0000);
        check({tag, " held"}, {q4, r4, dbz4}, {eq, er, ed});
    endtask

    task automatic run_div8(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] eq, input logic [7:0] er, input logic ed);
        int lat;
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, 9);
        check({tag, " Q"}, q8, eq);
        check({tag, " R"}, r8, er);
        check({tag, " dbz"}, dbz8, ed);
        tick();
    endtask

    initial begin
        logic [7:0] ra, rb, mq, mr;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        start4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        tick();
        check("reset dut4", {busy4, done4, q4, r4, dbz4, st4}, 17'h0);
        check("reset dut8", {busy8, done8, q8, r8, dbz8, st8}, 21'h0);
        tick();
        rst = 1'b0;
        tick();

        run_div4("d200_7", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);
        run_div4("d255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8'd28, 4'd4, 1'b0, 1'b0);
        run_div4("d5_9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 8'd17, 4'd0, 1'b0, 1'b0);
        run_div4("dA5_0", 8'hA5, 4'd0, 8'hFF, 4'h5, 1'b1, 8'd0, 4'd5, 1'b0, 1'b0);
        run_div4("d9_3poke", 8'd9, 4'd3, 8'd3, 4'd0, 1'b0, 8'hFF, 4'h5, 1'b1, 1'b1);

        // start held high: one result every 9 cycles
        a4 = 8'd100;
        b4 = 4'd10;
        start4 = 1'b1;
        for (int c = 1; c <= 27; c++) begin
            tick();
            check("b2b done", done4, (c % 9) == 0);
            check("b2b busy", busy4, (c % 9) != 0);
            if ((c % 9) == 0) begin
                check("b2b Q", q4, 8'd10);
                check("b2b R", r4, 4'd0);
            end
            if (c == 27) start4 = 1'b0;
        end
        tick();
        check("b2b idle", {busy4, done4}, 2'b00);

        // reset abort in cycle 4 of a run
        a4 = 8'd200;
        b4 = 4'd7;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort outputs", {busy4, done4, q4, r4, dbz4, st4}, 17'h0);
        for (int c = 0; c < 12; c++) begin
            check("abort no done", done4, 1'b0);
            tick();
        end
        run_div4("post_abort", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8'd0, 4'd0, 1'b0, 1'b0);

        // N=M=8 sweep
        run_div8("w200_0", 8'd200, 8'd0, 8'hFF, 8'd200, 1'b1);
        run_div8("w255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        run_div8("w254_255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0);
        run_div8("w255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        run_div8("w123_45", 8'd123, 8'd45, 8'd2, 8'd33, 1'b0);
        run_div8("w250_7", 8'd250, 8'd7, 8'd35, 8'd5, 1'b0);
        run_div8("w1_255", 8'd1, 8'd255, 8'd0, 8'd1, 1'b0);
        run_div8("w0_0", 8'd0, 8'd0, 8'hFF, 8'd0, 1'b1);
        run_div8("w128_16", 8'd128, 8'd16, 8'd8, 8'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            mq = (rb == 0) ? 8'hFF : ra / rb;
            mr = (rb == 0) ? ra : ra % rb;
            run_div8("wrand", ra, rb, mq, mr, rb == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
